wb_io_arbiter: RTL and testbench
================================

Name: wb_io_arbiter

Overview:
- Round-robin arbiter that shares the single Wishbone IO slave port of the IO interconnect between NUM_MASTERS bus masters, e.g. the core IO port plus a DMA/debug master.
- Sits between the masters and the interconnect's wb_io_* master-side port.
- Grants whole cycles: ownership holds while the owner's cyc is high.
- Optional bus watchdog terminates hung transfers with err.

Parameters:
- NUM_MASTERS, 2, number of requesting masters, 2..4.
- TIMEOUT_CYCLES, 255, stalled-strobe cycles before watchdog err; 8-bit counter; legal 2..255.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- wbm_adr_i  in  32*NUM_MASTERS  master addresses, master k at [32k+31:32k].
- wbm_dat_i  in  32*NUM_MASTERS  master write data.
- wbm_sel_i  in  4*NUM_MASTERS  byte selects.
- wbm_we_i  in  NUM_MASTERS  write enables.
- wbm_cyc_i  in  NUM_MASTERS  cycle / request.
- wbm_stb_i  in  NUM_MASTERS  strobes.
- wbm_cti_i  in  3*NUM_MASTERS  cycle type.
- wbm_bte_i  in  2*NUM_MASTERS  burst type.
- wbm_dat_o  out  32*NUM_MASTERS  read data.
- wbm_ack_o  out  NUM_MASTERS  ack.
- wbm_err_o  out  NUM_MASTERS  err.
- wbm_rty_o  out  NUM_MASTERS  rty.
- wbs_adr_o  out  32  slave address.
- wbs_dat_o  out  32  slave write data.
- wbs_sel_o  out  4  slave byte selects.
- wbs_we_o  out  1  slave write enable.
- wbs_cyc_o  out  1  slave cycle.
- wbs_stb_o  out  1  slave strobe.
- wbs_cti_o  out  3  slave cycle type.
- wbs_bte_o  out  2  slave burst type.
- wbs_dat_i  in  32  slave read data.
- wbs_ack_i  in  1  slave ack.
- wbs_err_i  in  1  slave err.
- wbs_rty_i  in  1  slave rty.
- grant_o  out  NUM_MASTERS  one-hot current owner; 0 when idle.
- timeout_o  out  1  one-cycle pulse per watchdog event.

Behaviour:
- Reset, async on wb_rst_n_i low:
  - state=IDLE, grant_o=0, last_grant=NUM_MASTERS-1 (so master 0 wins first), timeout counter=0.
  - All outputs 0.
  - A reset mid-transfer drops wbs_cyc_o/wbs_stb_o immediately.
- State IDLE:
  - wbs_cyc_o=wbs_stb_o=0; all wbm_ack/err/rty_o=0.
  - If any wbm_cyc_i is high, register the winner: the first requester searching from last_grant+1 upward, modulo NUM_MASTERS. Next state is OWN.
  - Latency: request seen at edge N; wbs_cyc_o high during cycle N+1.
- State OWN:
  - All wbs_* outputs are driven combinationally from the granted master's inputs.
  - wbs_dat_i is broadcast to all wbm_dat_o.
  - wbs_ack/err/rty_i are routed only to the owner; non-owners see 0.
  - When the owner's wbm_cyc_i is low, go to IDLE, set last_grant=owner and clear grant_o. wbs_cyc_o is already low that cycle (pass-through).
- Handoff gap:
  - At least one IDLE cycle separates owners.
  - Other masters' requests during OWN are ignored until IDLE.
- Fairness: after master k releases, master k does not win again while another master requests.
- Simultaneous requests in IDLE: round-robin order decides the winner; a one-hot grant is always guaranteed.
- Owner drops cyc while a slave ack is in flight: the ack is not forwarded, since the owner no longer samples it.

Optional Feature:
- Macro: WB_IO_ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter increments each OWN cycle in which wbs_stb_o=1 and none of wbs_ack_i/err_i/rty_i is high.
  - The counter clears on any termination, when stb is low, or outside OWN.
  - When the counter equals TIMEOUT_CYCLES, enter ERR for one cycle:
    - wbs_cyc_o=wbs_stb_o=0;
    - owner's wbm_err_o=1;
    - timeout_o=1;
    - counter cleared.
  - ERR then returns to OWN, or to IDLE if the owner's cyc is low.
  - A slave ack arriving during ERR is discarded.
- Disabled:
  - No counter or ERR state.
  - timeout_o is tied to 0.
  - A hung slave holds the bus indefinitely.

Test Plan:
- Single master 0: cyc/stb raised at cycle 0, slave acks in cycle 3.
  - wbs_cyc_o high in cycle 1 with adr/dat matching master 0.
  - wbm_ack_o[0]=1 in cycle 3; grant_o=01.
  - Cycle after cyc drops: grant_o=00.
- Both masters request at the same edge after reset.
  - Master 0 is granted first.
  - On its release there is 1 IDLE cycle, then grant_o=10.
  - A re-request from master 0 during master 1's ownership waits.
- Master 1 holds cyc through 3 ack'd beats with cti=010; master 0 requests during beat 1.
  - No grant change until master 1 drops cyc.
  - wbm_ack_o[0] stays 0 throughout.
- Master 0 uses err/rty from the slave.
  - wbm_err_o[0] and wbm_rty_o[0] each pulse exactly where the slave asserts them.
  - Master 1's outputs stay 0.
- Timeout (macro on, TIMEOUT_CYCLES=4): master 0 stb held with no slave response.
  - After 4 stalled cycles, one cycle of wbm_err_o[0]=1, timeout_o=1, wbs_cyc_o=0.
  - With macro off: no err, stb stays high for 20 cycles.
- Assert wb_rst_n_i low asynchronously mid-OWN.
  - wbs_cyc_o, grant_o and all acks go 0 without a clock edge.
  - After release, master 0 has priority again.

Source files
------------

// File: rtl/wb_io_arbiter.sv
// wb_io_arbiter: round-robin arbiter sharing one Wishbone IO slave port among masters, optional WB_IO_ARB_TIMEOUT_EN watchdog
module wb_io_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("wb_io_arbiter: parameter out of range");
  end
`ifdef WB_IO_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, OWN, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, OWN} state_t;
`endif
  state_t state, state_nx;
  logic [IW-1:0] owner, owner_nx, last, last_nx, win;
  logic [NUM_MASTERS-1:0] grant, grant_nx;
  logic found, own, ocyc, term, tmo_err;
`ifdef WB_IO_ARB_TIMEOUT_EN
  logic [7:0] cnt, cnt_nx;
  assign tmo_err = state == ERR;
`else
  assign tmo_err = 1'b0;
`endif
  assign own  = state == OWN;
  assign ocyc = wbm_cyc_i[owner];
  assign term = wbs_ack_i | wbs_err_i | wbs_rty_i;
  always_comb begin
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++)
      if (!found && wbm_cyc_i[(int'(last) + i) % NUM_MASTERS]) begin
        win   = IW'((int'(last) + i) % NUM_MASTERS);
        found = 1'b1;
      end
  end
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    grant_nx = grant;
`ifdef WB_IO_ARB_TIMEOUT_EN
    cnt_nx   = '0;
`endif
    case (state)
      IDLE: if (found) begin
        state_nx = OWN;
        owner_nx = win;
        grant_nx = NUM_MASTERS'(1) << win;
      end
      OWN: if (!ocyc) begin
        state_nx = IDLE;
        last_nx  = owner;
        grant_nx = '0;
      end
`ifdef WB_IO_ARB_TIMEOUT_EN
      else if (wbs_stb_o && !term) begin
        if (cnt == 8'(TIMEOUT_CYCLES - 1)) state_nx = ERR;
        else cnt_nx = cnt + 8'd1;
      end
      ERR: if (!ocyc) begin
        state_nx = IDLE;
        last_nx  = owner;
        grant_nx = '0;
      end else state_nx = OWN;
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NUM_MASTERS - 1);
      grant <= '0;
`ifdef WB_IO_ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      grant <= grant_nx;
`ifdef WB_IO_ARB_TIMEOUT_EN
      cnt   <= cnt_nx;
`endif
    end
  assign wbs_cyc_o = own && ocyc;
  assign wbs_stb_o = own && ocyc && wbm_stb_i[owner];
  assign wbs_adr_o = own ? wbm_adr_i[32*owner +: 32] : '0;
  assign wbs_dat_o = own ? wbm_dat_i[32*owner +: 32] : '0;
  assign wbs_sel_o = own ? wbm_sel_i[4*owner +: 4] : '0;
  assign wbs_we_o  = own && wbm_we_i[owner];
  assign wbs_cti_o = own ? wbm_cti_i[3*owner +: 3] : '0;
  assign wbs_bte_o = own ? wbm_bte_i[2*owner +: 2] : '0;
  assign wbm_dat_o = own ? {NUM_MASTERS{wbs_dat_i}} : '0;
  assign wbm_ack_o = (own && ocyc && wbs_ack_i) ? grant : '0;
  assign wbm_err_o = ((own && ocyc && wbs_err_i) || tmo_err) ? grant : '0;
  assign wbm_rty_o = (own && ocyc && wbs_rty_i) ? grant : '0;
  assign grant_o   = grant;
  assign timeout_o = tmo_err;
endmodule

// File: tb/tb_wb_io_arbiter.sv
// tb_wb_io_arbiter: directed and randomized scoreboard bench for wb_io_arbiter
module tb_wb_io_arbiter;
  localparam int N = 2;
  localparam int TCYC = 4;
`ifdef WB_IO_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  typedef struct packed {
    logic [1:0]  grant;
    logic        cyc;
    logic        stb;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [1:0]  rty;
    logic        tmo;
    logic        bus;
    logic [73:0] bus_v;
    logic [63:0] mdat;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [63:0] m_adr, m_dat, wbm_dat_o;
  logic [7:0]  m_sel;
  logic [1:0]  m_we, m_cyc, m_stb, wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [5:0]  m_cti;
  logic [3:0]  m_bte;
  logic [31:0] s_dat, wbs_adr_o, wbs_dat_o;
  logic        s_ack, s_err, s_rty, wbs_we_o, wbs_cyc_o, wbs_stb_o, timeout_o;
  logic [3:0]  wbs_sel_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  int total = 0, bad = 0;
  bit mon_en = 1'b0;
  exp_t q[$];
  int r_own, r_last, r_cnt;
  bit r_err;
  wb_io_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TCYC)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic look();
    #4;
  endtask
  task automatic clear();
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0; s_dat = '0; s_ack = 0; s_err = 0; s_rty = 0;
  endtask
  task automatic do_reset();
    clear();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  function automatic logic [10:0] ctl();
    return {grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o};
  endfunction
  function automatic logic [73:0] busv();
    return {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o};
  endfunction
  task automatic model_step();
    exp_t e;
    logic c;
    if (r_own >= 0) begin
      e = '0;
      e.grant = 2'(1 << r_own);
      if (r_err) begin
        e.err = e.grant;
        e.tmo = 1'b1;
      end else begin
        c = m_cyc[r_own];
        e.bus = 1'b1;
        e.cyc = c;
        e.stb = c & m_stb[r_own];
        e.bus_v = {m_adr[32*r_own +: 32], m_dat[32*r_own +: 32], m_sel[4*r_own +: 4],
                   m_we[r_own], m_cti[3*r_own +: 3], m_bte[2*r_own +: 2]};
        e.mdat = {2{s_dat}};
        if (c) begin
          e.ack = s_ack ? e.grant : 2'b0;
          e.err = s_err ? e.grant : 2'b0;
          e.rty = s_rty ? e.grant : 2'b0;
        end
      end
      q.push_back(e);
    end
    if (r_own < 0) begin
      for (int i = 1; i <= N; i++)
        if (r_own < 0 && m_cyc[(r_last + i) % N]) r_own = (r_last + i) % N;
    end else if (r_err) begin
      r_err = 1'b0;
      if (!m_cyc[r_own]) begin r_last = r_own; r_own = -1; end
    end else if (!m_cyc[r_own]) begin
      r_last = r_own;
      r_own = -1;
      r_cnt = 0;
    end else if (TMO && m_stb[r_own] && !(s_ack || s_err || s_rty)) begin
      r_cnt++;
      if (r_cnt == TCYC) begin r_err = 1'b1; r_cnt = 0; end
    end else r_cnt = 0;
  endtask
  initial begin : mon
    logic [10:0] act;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        act = ctl();
        if (act != '0) begin
          if (q.size() == 0) check("mon_unexpected", act, '0);
          else begin
            e = q.pop_front();
            check("mon_ctl", act, {e.grant, e.cyc, e.stb, e.ack, e.err, e.rty, e.tmo});
            if (e.bus) begin
              check("mon_bus", busv(), e.bus_v);
              check("mon_rdat", wbm_dat_o, e.mdat);
            end
          end
        end
      end
    end
  end
  initial begin
    clear();
    m_cyc = 2'b11; m_stb = 2'b11; m_adr = 64'h1234_5678_9abc_def0; s_ack = 1; s_dat = 32'hdead_beef;
    #3;
    check("rst_ctl", ctl(), '0);
    check("rst_bus", busv(), '0);
    check("rst_rdat", wbm_dat_o, '0);
    do_reset();
    // single master 0 transfer
    tick();
    m_cyc = 2'b01; m_stb = 2'b01; m_adr[31:0] = 32'h1000_0040; m_dat[31:0] = 32'h0bad_f00d;
    look(); check("t1_idle", {grant_o, wbs_cyc_o}, 3'b000);
    tick(); look();
    check("t1_cyc", wbs_cyc_o, 1'b1);
    check("t1_adrdat", {wbs_adr_o, wbs_dat_o}, {32'h1000_0040, 32'h0bad_f00d});
    check("t1_grant", grant_o, 2'b01);
    tick(); tick();
    s_ack = 1; s_dat = 32'hcafe_0001;
    look();
    check("t1_ack", wbm_ack_o, 2'b01);
    check("t1_rdat", wbm_dat_o, {2{32'hcafe_0001}});
    tick();
    s_ack = 0; m_cyc = 0; m_stb = 0;
    look(); check("t1_drop_cyc", {grant_o, wbs_cyc_o}, 3'b010);
    tick(); look(); check("t1_release", grant_o, 2'b00);
    // simultaneous requests
    do_reset();
    tick(); m_cyc = 2'b11; m_stb = 2'b11;
    tick(); look(); check("t2_first", grant_o, 2'b01);
    tick(); m_cyc[0] = 0; m_stb[0] = 0;
    look(); check("t2_rel_cycle", grant_o, 2'b01);
    tick(); look(); check("t2_gap", {grant_o, wbs_cyc_o}, 3'b000);
    tick(); look(); check("t2_second", grant_o, 2'b10);
    m_cyc[0] = 1; m_stb[0] = 1;
    tick(); look(); check("t2_rereq_wait", grant_o, 2'b10);
    tick(); m_cyc[1] = 0; m_stb[1] = 0;
    tick(); look(); check("t2_gap2", grant_o, 2'b00);
    tick(); look(); check("t2_m0_again", grant_o, 2'b01);
    // master 1 burst, master 0 requests mid-burst
    do_reset();
    tick(); m_cyc = 2'b10; m_stb = 2'b10; m_cti = 6'b010_000;
    tick();
    for (int b = 0; b < 3; b++) begin
      s_ack = 1;
      if (b == 0) begin m_cyc[0] = 1; m_stb[0] = 1; end
      look();
      check("t3_beat", {grant_o, wbm_ack_o, wbs_cti_o}, {2'b10, 2'b10, 3'b010});
      tick();
    end
    s_ack = 0; m_cyc[1] = 0; m_stb[1] = 0;
    look(); check("t3_hold", {grant_o, wbm_ack_o}, 4'b1000);
    tick(); look(); check("t3_gap", grant_o, 2'b00);
    tick(); look(); check("t3_handoff", grant_o, 2'b01);
    // err / rty routing
    do_reset();
    tick(); m_cyc = 2'b01; m_stb = 2'b01;
    tick(); s_err = 1;
    look(); check("t4_err", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 6'b00_01_00);
    tick(); s_err = 0; s_rty = 1;
    look(); check("t4_rty", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 6'b00_00_01);
    tick(); s_rty = 0;
    look(); check("t4_quiet", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 6'b00_00_00);
    // watchdog
    do_reset();
    tick(); m_cyc = 2'b01; m_stb = 2'b01;
    tick();
`ifdef WB_IO_ARB_TIMEOUT_EN
    for (int i = 0; i < TCYC; i++) begin
      look(); check("t5_stall", {timeout_o, wbm_err_o, wbs_cyc_o}, 4'b0001);
      tick();
    end
    look(); check("t5_timeout", {timeout_o, wbm_err_o, wbs_cyc_o, wbs_stb_o}, 5'b1_01_00);
    tick(); look(); check("t5_resume", {timeout_o, wbm_err_o, wbs_cyc_o}, 4'b0001);
`else
    for (int i = 0; i < 20; i++) begin
      look(); check("t5_hung", {timeout_o, wbm_err_o, wbs_cyc_o, wbs_stb_o}, 5'b0_00_11);
      tick();
    end
`endif
    // async reset mid-ownership restores master 0 priority
    do_reset();
    tick(); m_cyc = 2'b01; m_stb = 2'b01;
    tick(); m_cyc = 2'b00; m_stb = 2'b00;
    tick(); m_cyc = 2'b10; m_stb = 2'b10;
    tick(); tick();
    s_ack = 1;
    look(); check("t6_pre", {grant_o, wbm_ack_o}, 4'b1010);
    #1 rst_n = 1'b0;
    #1 check("t6_async", {grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o}, '0);
    s_ack = 0; m_cyc = 2'b11; m_stb = 2'b11;
    #1 rst_n = 1'b1;
    tick(); look(); check("t6_prio", grant_o, 2'b01);
    // randomized scoreboard phase
    do_reset();
    r_own = -1; r_last = N - 1; r_cnt = 0; r_err = 1'b0;
    q.delete();
    mon_en = 1'b1;
    for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 5) == 0) m_cyc[k] = ~m_cyc[k];
        m_stb[k] = m_cyc[k] & ($urandom_range(0, 3) != 0);
      end
      m_adr = {$urandom, $urandom}; m_dat = {$urandom, $urandom};
      m_sel = 8'($urandom); m_we = 2'($urandom); m_cti = 6'($urandom); m_bte = 4'($urandom);
      s_dat = $urandom;
      s_ack = $urandom_range(0, 3) == 0;
      s_err = $urandom_range(0, 15) == 0;
      s_rty = $urandom_range(0, 15) == 0;
      model_step();
    end
    #6;
    mon_en = 1'b0;
    check("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
